// File: rtl/retire_monitor.sv
// retire_monitor: hardware bookkeeping beside the hart retire port.
// Seven saturating event counters, a run/halt/timeout state machine and a
// registered select-based readout port for a debug/CSR host.
module retire_monitor #(
    parameter int              CNT_W   = 32,
    parameter longint unsigned TIMEOUT = 40000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_retire_valid,
    input  logic [31:0]      i_retire_inst,
    input  logic             i_retire_trap,
    input  logic             i_retire_halt,
    input  logic             i_retire_dmem_ren,
    input  logic             i_retire_dmem_wen,
    input  logic [2:0]       i_sel,
    output logic [CNT_W-1:0] o_rdata,
    output logic [1:0]       o_state,
    output logic             o_done,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTED  = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    // Counter slots: 0 cycles, 1 instret, 2 traps, 3 loads, 4 stores,
    // 5 branches, 6 jumps. The slot number doubles as the readout select.
    localparam int N_CNT = 7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    // Pre-increment cycle value on which the last allowed run cycle is spent.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 64'd1);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_done;
    logic               r_timeout;
    logic [CNT_W-1:0]   r_cnt [N_CNT];
    logic [CNT_W-1:0]   r_rdata;
    logic [N_CNT-1:0]   w_inc;
    logic [N_CNT-1:0]   w_sat_vec;
    logic               w_sat_any;
    logic               w_to_hit;
    logic [6:0]         w_op;
    logic [CNT_W-1:0]   w_status;
    logic [CNT_W-1:0]   w_rd_nxt;
    logic               w_unused_inst;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
        return (en && (v != CNT_MAX)) ? (v + CNT_ONE) : v;
    endfunction

    assign w_op          = i_retire_inst[6:0];
    assign w_unused_inst = ^i_retire_inst[31:7];
    assign w_to_hit      = (r_cnt[0] == TO_LAST);

    // Per-counter increment requests for a run cycle; retire fields only
    // matter when the retire strobe is valid.
    always_comb begin
        w_inc    = '0;
        w_inc[0] = 1'b1;
        if (i_retire_valid) begin
            w_inc[1] = 1'b1;
            w_inc[2] = i_retire_trap;
            w_inc[3] = i_retire_dmem_ren;
            w_inc[4] = i_retire_dmem_wen;
            w_inc[5] = (w_op == OP_BRANCH);
            w_inc[6] = (w_op == OP_JAL) || (w_op == OP_JALR);
        end
    end

    // Flag any counter that has reached its ceiling for the status word.
    always_comb begin
        w_sat_vec = '0;
        for (int i = 0; i < N_CNT; i++) begin
            w_sat_vec[i] = (r_cnt[i] == CNT_MAX);
        end
        w_sat_any = |w_sat_vec;
    end

    // Next state: start always wins; in RUN a halt beats a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        if (i_start) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (i_retire_valid && i_retire_halt) begin
                w_state_nxt = S_HALTED;
            end else if (w_to_hit) begin
                w_state_nxt = S_TIMEOUT;
            end
        end
    end

    // State register with done/timeout flags registered alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= (w_state_nxt == S_HALTED) || (w_state_nxt == S_TIMEOUT);
            r_timeout <= (w_state_nxt == S_TIMEOUT);
        end
    end

    // Event counters: cleared by start, advanced only while running.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_CNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_start) begin
            for (int i = 0; i < N_CNT; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < N_CNT; i++) begin
                r_cnt[i] <= sat_inc(r_cnt[i], w_inc[i]);
            end
        end
    end

    // Readout mux over the pre-update counters and the status word.
    always_comb begin
        w_status      = '0;
        w_status[1:0] = r_state;
        w_status[2]   = r_done;
        w_status[3]   = w_sat_any;
        case (i_sel)
            3'd0:    w_rd_nxt = r_cnt[0];
            3'd1:    w_rd_nxt = r_cnt[1];
            3'd2:    w_rd_nxt = r_cnt[2];
            3'd3:    w_rd_nxt = r_cnt[3];
            3'd4:    w_rd_nxt = r_cnt[4];
            3'd5:    w_rd_nxt = r_cnt[5];
            3'd6:    w_rd_nxt = r_cnt[6];
            default: w_rd_nxt = w_status;
        endcase
    end

    // Registered readout, one cycle behind the select.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_nxt;
        end
    end

    assign o_rdata   = r_rdata;
    assign o_state   = r_state;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: three instances with different widths/limits
// share one stimulus stream and are compared every cycle against a
// behavioural model, with literal expectations for the directed scenarios.
module tb_retire_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        v;
    logic [31:0] inst;
    logic        trap;
    logic        halt;
    logic        ren;
    logic        wen;
    logic [2:0]  sel;

    logic [31:0] rd0;
    logic [7:0]  rd1;
    logic [7:0]  rd2;
    logic [1:0]  st0, st1, st2;
    logic        dn0, dn1, dn2;
    logic        to0, to1, to2;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] ADDI   = 32'h0000_0013;

    always #5 clk = ~clk;

    // Instance 0: wide counters, moderate limit.
    retire_monitor #(.CNT_W(32), .TIMEOUT(200)) u_main (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_retire_valid(v),
        .i_retire_inst(inst), .i_retire_trap(trap), .i_retire_halt(halt),
        .i_retire_dmem_ren(ren), .i_retire_dmem_wen(wen), .i_sel(sel),
        .o_rdata(rd0), .o_state(st0), .o_done(dn0), .o_timeout(to0));

    // Instance 1: very short watchdog.
    retire_monitor #(.CNT_W(8), .TIMEOUT(8)) u_short (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_retire_valid(v),
        .i_retire_inst(inst), .i_retire_trap(trap), .i_retire_halt(halt),
        .i_retire_dmem_ren(ren), .i_retire_dmem_wen(wen), .i_sel(sel),
        .o_rdata(rd1), .o_state(st1), .o_done(dn1), .o_timeout(to1));

    // Instance 2: narrow counters with the largest legal limit.
    retire_monitor #(.CNT_W(8), .TIMEOUT(255)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_retire_valid(v),
        .i_retire_inst(inst), .i_retire_trap(trap), .i_retire_halt(halt),
        .i_retire_dmem_ren(ren), .i_retire_dmem_wen(wen), .i_sel(sel),
        .o_rdata(rd2), .o_state(st2), .o_done(dn2), .o_timeout(to2));

    // ---------------- behavioural model ----------------
    longint unsigned mmax [3] = '{64'hFFFF_FFFF, 64'hFF, 64'hFF};
    longint unsigned mto  [3] = '{64'd200, 64'd8, 64'd255};
    longint unsigned m_cnt [3][7];
    int              m_st  [3];
    longint unsigned m_rd  [3];

    function automatic bit counts_event(int i);
        logic [6:0] op;
        op = inst[6:0];
        case (i)
            0:       return 1'b1;
            1:       return v;
            2:       return v && trap;
            3:       return v && ren;
            4:       return v && wen;
            5:       return v && (op == 7'h63);
            default: return v && ((op == 7'h6F) || (op == 7'h67));
        endcase
    endfunction

    function automatic longint unsigned nxt_cnt(int k, int i);
        if (start) return 0;
        if (m_st[k] != 1) return m_cnt[k][i];
        if (counts_event(i) && (m_cnt[k][i] < mmax[k])) return m_cnt[k][i] + 1;
        return m_cnt[k][i];
    endfunction

    function automatic int nxt_st(int k);
        if (start) return 1;
        if (m_st[k] != 1) return m_st[k];
        if (v && halt) return 2;
        if (m_cnt[k][0] == mto[k] - 1) return 3;
        return 1;
    endfunction

    function automatic longint unsigned rd_val(int k);
        longint unsigned w;
        bit sat;
        if (sel == 3'd7) begin
            sat = 1'b0;
            for (int i = 0; i < 7; i++) if (m_cnt[k][i] == mmax[k]) sat = 1'b1;
            w = longint'(m_st[k]);
            if (m_st[k] >= 2) w = w + 4;
            if (sat) w = w + 8;
            return w;
        end
        return m_cnt[k][sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 7; i++) m_cnt[k][i] <= 0;
                m_st[k] <= 0;
                m_rd[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 7; i++) m_cnt[k][i] <= nxt_cnt(k, i);
                m_st[k] <= nxt_st(k);
                m_rd[k] <= rd_val(k);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint unsigned dut_rd(int k);
        case (k)
            0:       return longint'(rd0);
            1:       return longint'(rd1);
            default: return longint'(rd2);
        endcase
    endfunction

    function automatic longint unsigned dut_st(int k);
        case (k)
            0:       return longint'(st0);
            1:       return longint'(st1);
            default: return longint'(st2);
        endcase
    endfunction

    function automatic longint unsigned dut_dn(int k);
        case (k)
            0:       return longint'(dn0);
            1:       return longint'(dn1);
            default: return longint'(dn2);
        endcase
    endfunction

    function automatic longint unsigned dut_to(int k);
        case (k)
            0:       return longint'(to0);
            1:       return longint'(to1);
            default: return longint'(to2);
        endcase
    endfunction

    // Every cycle, away from the rising edge, all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rdata[%0d]", k), dut_rd(k), m_rd[k]);
            chk($sformatf("state[%0d]", k), dut_st(k), longint'(m_st[k]));
            chk($sformatf("done[%0d]", k), dut_dn(k), (m_st[k] >= 2) ? 1 : 0);
            chk($sformatf("timeout[%0d]", k), dut_to(k), (m_st[k] == 3) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    // Apply one cycle of inputs (called just after a falling edge) and return
    // after the following falling edge, when the registered outputs are stable.
    task automatic cyc(input logic s, input logic vv, input logic [31:0] in,
                       input logic tr, input logic hl, input logic rn,
                       input logic wn, input logic [2:0] sl);
        start = s; v = vv; inst = in; trap = tr; halt = hl;
        ren = rn; wen = wn; sel = sl;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [2:0] sl);
        for (int j = 0; j < n; j++) cyc(0, 0, ADDI, 0, 0, 0, 0, sl);
    endtask

    logic [6:0] ops [5] = '{7'h63, 7'h6F, 7'h67, 7'h03, 7'h23};

    initial begin
        logic [31:0] r;
        rst_n = 1'b1;
        start = 0; v = 0; inst = ADDI; trap = 0; halt = 0; ren = 0; wen = 0; sel = 0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state", longint'(st0), 0);
        chk("reset_rdata", longint'(rd0), 0);
        #1 rst_n = 1'b1;
        idle(2, 3'd0);
        chk("idle_cycles_hold", longint'(rd0), 0);

        // Ten retires over fifteen cycles, ending in ebreak.
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd0);
        for (int j = 1; j <= 15; j++) begin
            if (j == 15) cyc(0, 1, EBREAK, 0, 1, 0, 0, 3'd0);
            else         cyc(0, (j >= 6), ADDI, 0, 0, 0, 0, 3'd0);
        end
        chk("halt_state", longint'(st0), 2);
        chk("halt_done", longint'(dn0), 1);
        chk("halt_timeout", longint'(to0), 0);
        idle(5, 3'd0);
        chk("halt_cycles", longint'(rd0), 15);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd1);
        chk("halt_instret", longint'(rd0), 10);

        // Mixed stream of classified instructions.
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd0);
        cyc(0, 1, 32'h0000_2003, 0, 0, 1, 0, 3'd0);
        cyc(0, 1, 32'h0000_2023, 0, 0, 0, 1, 3'd0);
        cyc(0, 1, 32'h0000_0063, 0, 0, 0, 0, 3'd0);
        cyc(0, 1, 32'h0000_006F, 0, 0, 0, 0, 3'd0);
        cyc(0, 1, 32'h0000_8067, 1, 0, 0, 0, 3'd0);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd1);
        chk("mix_instret", longint'(rd0), 5);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd2);
        chk("mix_traps", longint'(rd0), 1);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd3);
        chk("mix_loads", longint'(rd0), 1);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd4);
        chk("mix_stores", longint'(rd0), 1);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd5);
        chk("mix_branches", longint'(rd0), 1);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd6);
        chk("mix_jumps", longint'(rd0), 2);

        // Short watchdog: eight run cycles then TIMEOUT; halt on the eighth wins.
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd0);
        idle(7, 3'd0);
        chk("to_still_run", longint'(st1), 1);
        idle(1, 3'd0);
        chk("to_state", longint'(st1), 3);
        chk("to_flag", longint'(to1), 1);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd0);
        chk("to_cycles", longint'(rd1), 8);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd7);
        chk("to_status", longint'(rd1), 7);
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd0);
        idle(7, 3'd0);
        cyc(0, 1, EBREAK, 0, 1, 0, 0, 3'd0);
        chk("to_halt_wins", longint'(st1), 2);
        chk("to_halt_noflag", longint'(to1), 0);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd0);
        chk("to_halt_cycles", longint'(rd1), 8);

        // Narrow counters saturate together with the watchdog.
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd0);
        for (int j = 0; j < 255; j++) cyc(0, 1, ADDI, 0, 0, 0, 0, 3'd0);
        chk("sat_state", longint'(st2), 3);
        idle(3, 3'd1);
        chk("sat_instret", longint'(rd2), 255);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd0);
        chk("sat_cycles", longint'(rd2), 255);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd7);
        chk("sat_status", longint'(rd2), 15);

        // Start mid-run with a valid retire in the same cycle.
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd0);
        for (int j = 0; j < 3; j++) cyc(0, 1, 32'h0000_2003, 0, 0, 1, 0, 3'd0);
        cyc(1, 1, 32'h0000_2003, 0, 0, 1, 0, 3'd0);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd1);
        chk("restart_instret", longint'(rd0), 0);
        chk("restart_state", longint'(st0), 1);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd3);
        chk("restart_loads", longint'(rd0), 0);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd0);
        chk("restart_cycles", longint'(rd0), 2);

        // Asynchronous reset in the middle of a run.
        cyc(1, 0, ADDI, 0, 0, 0, 0, 3'd1);
        for (int j = 0; j < 4; j++) cyc(0, 1, ADDI, 0, 0, 0, 0, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", longint'(st0), 0);
        chk("arst_done", longint'(dn0), 0);
        chk("arst_rdata", longint'(rd0), 0);
        chk("arst_short_state", longint'(st1), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd0);
        cyc(0, 0, ADDI, 0, 0, 0, 0, 3'd0);
        chk("arst_cycles", longint'(rd0), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            if ($urandom_range(0, 5) != 5) r[6:0] = ops[$urandom_range(0, 4)];
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) < 6), r,
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0),
                1'($urandom), 1'($urandom), 3'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/retire_monitor.md
# retire_monitor

Synthesizable retire-stream monitor that sits beside the `hart` retire interface and replaces simulation-only cycle and instruction bookkeeping with hardware counters. It counts run cycles, retired instructions, traps, loads, stores, branches and jumps. It detects halt and enforces a watchdog timeout. Counters are read through a registered select port by a debug/CSR host or the testbench.

## Interface
Parameters:
- `CNT_W`, 32, width of every counter and of `o_rdata` (8..64).
- `TIMEOUT`, 40000, run-cycle limit before the watchdog fires; must satisfy 1 <= `TIMEOUT` <= 2^`CNT_W`-1.

Ports:
- `i_clk` in 1: clock; all state changes on rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_start` in 1: clear all counters and enter RUN; honoured in every state.
- `i_retire_valid` in 1: an instruction retires this cycle.
- `i_retire_inst` in 32: retired instruction word; used only when valid.
- `i_retire_trap` in 1: the retiring instruction trapped.
- `i_retire_halt` in 1: the retiring instruction halts the hart.
- `i_retire_dmem_ren` in 1: the retiring instruction performed a load.
- `i_retire_dmem_wen` in 1: the retiring instruction performed a store.
- `i_sel` in 3: readout select. 0 cycles, 1 instret, 2 traps, 3 loads, 4 stores, 5 branches, 6 jumps, 7 status.
- `o_rdata` out `CNT_W`: registered readout.
- `o_state` out 2: 0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT.
- `o_done` out 1: high in HALTED or TIMEOUT.
- `o_timeout` out 1: high in TIMEOUT only.

## Operation
- Reset (async assert, sync-safe deassert): state IDLE, all seven counters 0, `o_rdata` 0, `o_done` 0, `o_timeout` 0, `o_state` 0.
- IDLE: counters hold. `i_start` moves the block to RUN.
- RUN, per cycle:
  - `cycles` +1.
  - If `i_retire_valid`:
    - `instret` +1.
    - `traps` +1 if trap.
    - `loads` +1 if ren.
    - `stores` +1 if wen.
    - `branches` +1 if inst[6:0]=1100011.
    - `jumps` +1 if inst[6:0] is 1101111 or 1100111.
  - Retire inputs are ignored when valid is 0.
- RUN exits:
  - valid & halt → HALTED. The halting instruction and its cycle are counted.
  - Otherwise, if the pre-increment `cycles` equals `TIMEOUT`-1 → TIMEOUT. Exactly `TIMEOUT` cycles are counted.
  - If halt and the timeout condition occur in the same cycle, halt wins and the block enters HALTED.
- HALTED / TIMEOUT: counters frozen and retire inputs ignored. Leave only via `i_start` or reset.
- `i_start` in any state, including mid-RUN:
  - All counters are cleared to 0 on that edge and the state becomes RUN.
  - Retire inputs in the `i_start` cycle are not counted.
  - The `i_start` cycle is not counted. The first counted cycle is the next one.
- Saturation: every counter stops at 2^`CNT_W`-1 and never wraps. The timeout normally fires first for `cycles`.
- Status word (`i_sel`=7): bits [1:0] `o_state`, bit 2 `o_done`, bit 3 any-counter-saturated, remaining bits 0.
- Values of `i_sel` are all legal; there is no undefined select.

## Timing
- `o_rdata` has 1-cycle latency: it shows the value selected at edge N, using counter values before edge N's update.
- `o_state`, `o_done` and `o_timeout` are registered and change on the same edge as the state transition.
- Throughput: one retire event per cycle is counted with no stall. There is no backpressure to the hart.
- Counters and state update on the same edge. A halt retiring at edge N gives `o_done`=1 after edge N, and `instret` includes it.

## Test plan
- Reset mid-RUN with counters nonzero: drive `i_rst_n`=0 asynchronously → `o_state`=0, `o_done`=0 and all counters 0 immediately; after release, reading `i_sel`=0 returns 0.
- Start, then retire 10 instructions over 15 cycles, ending with a halt (ebreak 0x00100073) on the 15th cycle → HALTED; `cycles`=15, `instret`=10, `o_done`=1, `o_timeout`=0; `cycles` is still 15 five cycles later.
- Mixed stream: valid with a load, store, beq (0x00000063), jal (0x0000006F), jalr (0x00008067), and one trap → loads=1, stores=1, branches=1, jumps=2, traps=1, instret=5.
- `TIMEOUT`=8, start with no halt → TIMEOUT after 8 run cycles; `cycles`=8, `o_timeout`=1, status word=0x7; halt on the 8th cycle instead gives HALTED.
- `CNT_W`=8, `TIMEOUT`=255, valid every cycle → `instret` reaches 255; at that point `cycles`=255, TIMEOUT, and the status saturated bit=1.
- `i_start` asserted mid-RUN with valid=1 in the same cycle → all counters read 0 one cycle later; that instruction is not counted; state stays RUN.
